// File: rtl/mem_access_if.sv
// mem_access_if
// Data-memory bus between the memory-access stage (master) and the data
// memory or its interconnect (slave). Request/grant for the address phase,
// rvalid for the read-data phase.
//   req    master->slave  bus request
//   we     master->slave  1 = write
//   addr   master->slave  word-aligned byte address
//   be     master->slave  byte enables (zero for reads)
//   wdata  master->slave  lane-replicated write data
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  read data valid
//   rdata  slave->master  read data
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_access.sv
// mem_access
// Memory-access stage of the five-stage pipeline. Takes the EX/MEM register
// contents, runs loads and stores over the data-memory bus, stalls upstream
// while an access is outstanding, aligns/extends load data and registers the
// selected writeback value into the MEM/WB register.
// Ports:
//   clk, reset              pipeline clock, asynchronous active-low reset
//   *_in                    EX/MEM register fields
//   dmem                    data-memory bus (master side)
//   mem_forward             exec_in passed straight through for forwarding
//   stall_out               holds IF/ID/EX while an access is in flight
//   valid_out .. misaligned_out  MEM/WB register
module mem_access (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic               rd_write_enable_in,
  input  logic [4:0]         rd_write_addr_in,
  input  logic [1:0]         res_src_in,
  input  logic               mem_write_enable_in,
  input  logic [2:0]         mem_width_in,
  input  logic [31:0]        exec_in,
  input  logic [31:0]        mem_write_data_in,
  input  logic [31:0]        next_pc_in,
  mem_access_if.master       dmem,
  output logic [31:0]        mem_forward,
  output logic               stall_out,
  output logic               valid_out,
  output logic               rd_write_enable_out,
  output logic [4:0]         rd_write_addr_out,
  output logic [31:0]        wb_data_out,
  output logic               misaligned_out
);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  state_t      state_reg;
  logic [1:0]  lane_reg;
  logic [2:0]  width_reg;

  logic        is_store;
  logic        access;
  logic        width_illegal;
  logic        addr_bad;
  logic        misaligned;
  logic        req;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] wb_next;

  assign is_store    = mem_write_enable_in;
  assign mem_forward = exec_in;

  always_comb begin
    access = valid_in && (res_src_in == 2'b01 || mem_write_enable_in);

    // BU/HU only exist as loads; 011/110/111 are not defined at all.
    unique case (mem_width_in)
      3'b000, 3'b001, 3'b010: width_illegal = 1'b0;
      3'b100, 3'b101:         width_illegal = is_store;
      default:                width_illegal = 1'b1;
    endcase

    // Low two width bits give the access size for every legal encoding.
    unique case (mem_width_in[1:0])
      2'b01:   addr_bad = exec_in[0];
      2'b10:   addr_bad = (exec_in[1:0] != 2'b00);
      default: addr_bad = 1'b0;
    endcase

    misaligned = access && (width_illegal || addr_bad);
  end

  // Request is only raised from IDLE; bad accesses never reach the bus.
  assign req = reset && (state_reg == IDLE) && access && !misaligned;

  assign dmem.req  = req;
  assign dmem.we   = is_store;
  assign dmem.addr = {exec_in[31:2], 2'b00};

  always_comb begin
    dmem.be = 4'b0000;
    if (is_store) begin
      unique case (mem_width_in[1:0])
        2'b00:   dmem.be = 4'b0001 << exec_in[1:0];
        2'b01:   dmem.be = 4'b0011 << exec_in[1:0];
        default: dmem.be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    unique case (mem_width_in[1:0])
      2'b00:   dmem.wdata = {4{mem_write_data_in[7:0]}};
      2'b01:   dmem.wdata = {2{mem_write_data_in[15:0]}};
      default: dmem.wdata = mem_write_data_in;
    endcase
  end

  // A granted store finishes in the request cycle; a granted load still
  // has to wait for its data, so it stalls regardless of gnt.
  always_comb begin
    if (state_reg == WAIT_RSP)
      stall_out = !dmem.rvalid;
    else
      stall_out = req && (!is_store || !dmem.gnt);
  end

  // Load extraction uses the lane/width captured at grant time.
  always_comb begin
    unique case (lane_reg)
      2'd0:    load_byte = dmem.rdata[7:0];
      2'd1:    load_byte = dmem.rdata[15:8];
      2'd2:    load_byte = dmem.rdata[23:16];
      default: load_byte = dmem.rdata[31:24];
    endcase
    load_half = lane_reg[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

    unique case (width_reg)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'h000000, load_byte};
      3'b101:  load_data = {16'h0000, load_half};
      default: load_data = dmem.rdata;
    endcase
  end

  // Load data is only meaningful on the rvalid cycle; a misaligned load
  // retires with zero data.
  always_comb begin
    unique case (res_src_in)
      2'b00:   wb_next = exec_in;
      2'b01:   wb_next = (state_reg == WAIT_RSP) ? load_data : 32'h0;
      2'b10:   wb_next = next_pc_in;
      default: wb_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg           <= IDLE;
      lane_reg            <= 2'b00;
      width_reg           <= 3'b000;
      valid_out           <= 1'b0;
      rd_write_enable_out <= 1'b0;
      rd_write_addr_out   <= 5'd0;
      wb_data_out         <= 32'h0;
      misaligned_out      <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (req && dmem.gnt && !is_store) begin
            state_reg <= WAIT_RSP;
            lane_reg  <= exec_in[1:0];
            width_reg <= mem_width_in;
          end
        end
        default: begin
          if (dmem.rvalid)
            state_reg <= IDLE;
        end
      endcase

      if (stall_out) begin
        valid_out           <= 1'b0;
        rd_write_enable_out <= 1'b0;
        rd_write_addr_out   <= 5'd0;
        wb_data_out         <= 32'h0;
        misaligned_out      <= 1'b0;
      end else begin
        valid_out           <= valid_in;
        rd_write_enable_out <= rd_write_enable_in && !misaligned;
        rd_write_addr_out   <= rd_write_addr_in;
        wb_data_out         <= wb_next;
        misaligned_out      <= misaligned;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
// Directed bench for mem_access. A per-cycle reference model of the stage
// (outstanding-load flag plus size/lane arithmetic) runs in one compare
// process on every falling edge; directed transactions add hand-computed
// literal expectations on retired values and stall counts.
module tb_mem_access;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        valid_in, rd_write_enable_in, mem_write_enable_in;
  logic [4:0]  rd_write_addr_in;
  logic [1:0]  res_src_in;
  logic [2:0]  mem_width_in;
  logic [31:0] exec_in, mem_write_data_in, next_pc_in;
  logic [31:0] mem_forward, wb_data_out;
  logic        stall_out, valid_out, rd_write_enable_out, misaligned_out;
  logic [4:0]  rd_write_addr_out;

  mem_access_if dmem ();

  mem_access dut (
    .clk                 (clk),
    .reset               (reset),
    .valid_in            (valid_in),
    .rd_write_enable_in  (rd_write_enable_in),
    .rd_write_addr_in    (rd_write_addr_in),
    .res_src_in          (res_src_in),
    .mem_write_enable_in (mem_write_enable_in),
    .mem_width_in        (mem_width_in),
    .exec_in             (exec_in),
    .mem_write_data_in   (mem_write_data_in),
    .next_pc_in          (next_pc_in),
    .dmem                (dmem),
    .mem_forward         (mem_forward),
    .stall_out           (stall_out),
    .valid_out           (valid_out),
    .rd_write_enable_out (rd_write_enable_out),
    .rd_write_addr_out   (rd_write_addr_out),
    .wb_data_out         (wb_data_out),
    .misaligned_out      (misaligned_out)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic        pending = 1'b0;
  logic        e_valid = 1'b0, e_rwe = 1'b0, e_mis = 1'b0, e_chk_data = 1'b1;
  logic [4:0]  e_rd = 5'd0;
  logic [31:0] e_data = 32'h0;

  function automatic logic [31:0] load_value(input logic [31:0] rd, input logic [1:0] lane,
                                             input logic [2:0] w);
    logic [31:0] x, b, h;
    x = rd >> {lane, 3'b000};
    b = x & 32'h0000_00FF;
    h = x & 32'h0000_FFFF;
    case (w)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  always @(negedge clk) begin : compare
    logic acc, st, legal, bad, req_e, stall_e, retire_load;
    int sz;
    logic [3:0]  be_e;
    logic [31:0] wd_e, data_e;

    if (!reset) begin
      pending = 1'b0;
      e_valid = 1'b0; e_rwe = 1'b0; e_rd = 5'd0; e_data = 32'h0; e_mis = 1'b0; e_chk_data = 1'b1;
    end

    chk("m_valid_out", 32'(valid_out), 32'(e_valid));
    chk("m_rd_we_out", 32'(rd_write_enable_out), 32'(e_rwe));
    chk("m_rd_addr_out", 32'(rd_write_addr_out), 32'(e_rd));
    chk("m_misaligned_out", 32'(misaligned_out), 32'(e_mis));
    if (e_chk_data) chk("m_wb_data_out", wb_data_out, e_data);
    chk("m_mem_forward", mem_forward, exec_in);
    chk("m_dmem_addr", dmem.addr, exec_in & 32'hFFFF_FFFC);

    if (!reset) begin
      chk("m_req_in_reset", 32'(dmem.req), 32'h0);
    end else begin
      st    = mem_write_enable_in;
      acc   = valid_in && (res_src_in == 2'b01 || st);
      legal = st ? (mem_width_in <= 3'd2)
                 : (mem_width_in inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      sz    = 1 << mem_width_in[1:0];
      bad   = acc && (!legal || (exec_in % sz) != 0);
      retire_load = 1'b0;

      if (pending) begin
        req_e   = 1'b0;
        stall_e = !dmem.rvalid;
        if (dmem.rvalid) begin
          pending = 1'b0;
          retire_load = 1'b1;
        end
      end else begin
        req_e   = acc && !bad;
        stall_e = req_e && (!st || !dmem.gnt);
        if (req_e && !st && dmem.gnt) pending = 1'b1;
      end

      chk("m_dmem_req", 32'(dmem.req), 32'(req_e));
      chk("m_stall_out", 32'(stall_out), 32'(stall_e));
      if (req_e) begin
        chk("m_dmem_we", 32'(dmem.we), 32'(st));
        if (st) begin
          for (int i = 0; i < 4; i++)
            be_e[i] = (i >= int'(exec_in[1:0])) && (i < int'(exec_in[1:0]) + sz);
          case (sz)
            1:       wd_e = {24'h0, mem_write_data_in[7:0]} * 32'h0101_0101;
            2:       wd_e = {16'h0, mem_write_data_in[15:0]} * 32'h0001_0001;
            default: wd_e = mem_write_data_in;
          endcase
          chk("m_dmem_be", 32'(dmem.be), 32'(be_e));
          chk("m_dmem_wdata", dmem.wdata, wd_e);
        end else begin
          chk("m_dmem_be_load", 32'(dmem.be), 32'h0);
        end
      end

      case (res_src_in)
        2'b00:   data_e = exec_in;
        2'b01:   data_e = retire_load ? load_value(dmem.rdata, exec_in[1:0], mem_width_in) : 32'h0;
        2'b10:   data_e = next_pc_in;
        default: data_e = 32'h0;
      endcase

      if (stall_e) begin
        e_valid = 1'b0; e_rwe = 1'b0; e_rd = 5'd0; e_data = 32'h0; e_mis = 1'b0; e_chk_data = 1'b1;
      end else begin
        e_valid = valid_in;
        e_rwe   = rd_write_enable_in && !bad;
        e_rd    = rd_write_addr_in;
        e_data  = data_e;
        e_mis   = bad;
        e_chk_data = !bad;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input logic v, input logic rwe, input logic [4:0] rd, input logic [1:0] rs,
                        input logic we, input logic [2:0] w, input logic [31:0] ex,
                        input logic [31:0] wd, input logic [31:0] np);
    valid_in = v; rd_write_enable_in = rwe; rd_write_addr_in = rd; res_src_in = rs;
    mem_write_enable_in = we; mem_width_in = w; exec_in = ex; mem_write_data_in = wd;
    next_pc_in = np;
  endtask

  task automatic bubble();
    set_op(1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic bus_idle();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 32'h0;
  endtask

  // One-cycle instruction; ends on the falling edge where it is visible in MEM/WB.
  task automatic single(input string name, input logic [1:0] rs, input logic st, input logic [2:0] w,
                        input logic [31:0] addr, input logic [31:0] np,
                        output logic req_s, output logic stall_s);
    @(posedge clk); #2;
    set_op(1'b1, 1'b1, 5'd9, rs, st, w, addr, 32'hCAFE_F00D, np);
    bus_idle();
    @(negedge clk);
    req_s = dmem.req; stall_s = stall_out;
    @(posedge clk); #2;
    bubble();
    @(negedge clk);
    $display("txn %s addr=%h wb=%h mis=%0d", name, addr, wb_data_out, misaligned_out);
  endtask

  // Bus access with gnt after gd cycles and (loads) rvalid rdl cycles after gnt.
  task automatic run_access(input string name, input logic st, input logic [2:0] w,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                            input int gd, input int rdl, input logic hold,
                            output int stalls, output int reqs, output int bubbles,
                            output logic [3:0] be_seen, output logic [31:0] wdata_seen,
                            output logic [31:0] addr_seen);
    bit last;
    stalls = 0; reqs = 0; bubbles = 0; be_seen = 4'h0; wdata_seen = 32'h0; addr_seen = 32'h0;
    @(posedge clk); #2;
    set_op(1'b1, !st, 5'd7, st ? 2'b00 : 2'b01, st, w, addr, wd, 32'h0);
    for (int c = 0; c < 64; c++) begin
      dmem.gnt    = hold ? (c >= gd) : (c == gd);
      dmem.rvalid = !st && (c == gd + rdl);
      dmem.rdata  = (c == gd + rdl) ? rdat : 32'h0;
      @(negedge clk);
      if (stall_out) stalls++;
      if (dmem.req) begin
        reqs++; be_seen = dmem.be; wdata_seen = dmem.wdata; addr_seen = dmem.addr;
      end
      if (c >= 1 && !valid_out) bubbles++;
      last = st ? (c == gd) : (c == gd + rdl);
      @(posedge clk); #2;
      if (last) break;
    end
    bus_idle();
    bubble();
    @(negedge clk);
    $display("txn %s addr=%h wb=%h stalls=%0d reqs=%0d", name, addr, wb_data_out, stalls, reqs);
  endtask

  initial begin
    logic req_s, stall_s;
    int stalls, reqs, bubbles;
    logic [3:0] be_s;
    logic [31:0] wd_s, ad_s;

    bubble();
    bus_idle();
    #1 reset = 1'b0;

    // aligned load presented during reset must not reach the bus
    @(posedge clk); #2;
    set_op(1'b1, 1'b1, 5'd3, 2'b01, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0);
    @(negedge clk);
    chk("reset_req", 32'(dmem.req), 32'h0);
    chk("reset_valid_out", 32'(valid_out), 32'h0);
    chk("reset_wb_data", wb_data_out, 32'h0);
    @(posedge clk); #2;
    bubble();
    reset = 1'b1;

    single("alu", 2'b00, 1'b0, 3'b010, 32'h0000_1234, 32'h0, req_s, stall_s);
    chk("alu_wb", wb_data_out, 32'h0000_1234);
    chk("alu_valid", 32'(valid_out), 32'h1);
    chk("alu_rd", 32'(rd_write_addr_out), 32'd9);
    chk("alu_req", 32'(req_s), 32'h0);
    chk("alu_stall", 32'(stall_s), 32'h0);

    run_access("lb", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 1, 1'b0,
               stalls, reqs, bubbles, be_s, wd_s, ad_s);
    chk("lb_wb", wb_data_out, 32'hFFFF_FF80);
    chk("lb_stalls", 32'(stalls), 32'd1);
    chk("lb_rd_we", 32'(rd_write_enable_out), 32'h1);

    run_access("lbu", 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 1, 1'b0,
               stalls, reqs, bubbles, be_s, wd_s, ad_s);
    chk("lbu_wb", wb_data_out, 32'h0000_0080);
    chk("lbu_stalls", 32'(stalls), 32'd1);

    run_access("sh", 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 2, 0, 1'b0,
               stalls, reqs, bubbles, be_s, wd_s, ad_s);
    chk("sh_stalls", 32'(stalls), 32'd2);
    chk("sh_req_cycles", 32'(reqs), 32'd3);
    chk("sh_be", 32'(be_s), 32'h0000_000C);
    chk("sh_wdata", wd_s, 32'hBEEF_BEEF);
    chk("sh_addr", ad_s, 32'h0000_2000);

    single("lw_mis", 2'b01, 1'b0, 3'b010, 32'h0000_3001, 32'h0, req_s, stall_s);
    chk("lwmis_req", 32'(req_s), 32'h0);
    chk("lwmis_stall", 32'(stall_s), 32'h0);
    chk("lwmis_flag", 32'(misaligned_out), 32'h1);
    chk("lwmis_rd_we", 32'(rd_write_enable_out), 32'h0);

    single("jal", 2'b10, 1'b0, 3'b000, 32'h0000_0000, 32'h0000_0040, req_s, stall_s);
    chk("jal_wb", wb_data_out, 32'h0000_0040);

    // gnt held high, so it is also high in the rvalid cycle
    run_access("lw_wait3", 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h1234_5678, 0, 3, 1'b1,
               stalls, reqs, bubbles, be_s, wd_s, ad_s);
    chk("lw3_wb", wb_data_out, 32'h1234_5678);
    chk("lw3_stalls", 32'(stalls), 32'd3);
    chk("lw3_bubbles", 32'(bubbles), 32'd3);
    chk("lw3_req_cycles", 32'(reqs), 32'd1);

    run_access("lh", 1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_0000, 1, 1, 1'b0,
               stalls, reqs, bubbles, be_s, wd_s, ad_s);
    chk("lh_wb", wb_data_out, 32'hFFFF_8001);
    chk("lh_stalls", 32'(stalls), 32'd2);

    run_access("lhu", 1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h8001_0000, 0, 2, 1'b0,
               stalls, reqs, bubbles, be_s, wd_s, ad_s);
    chk("lhu_wb", wb_data_out, 32'h0000_8001);

    run_access("sw", 1'b1, 3'b010, 32'h0000_4000, 32'h1122_3344, 32'h0, 0, 0, 1'b0,
               stalls, reqs, bubbles, be_s, wd_s, ad_s);
    chk("sw_stalls", 32'(stalls), 32'd0);
    chk("sw_be", 32'(be_s), 32'h0000_000F);
    chk("sw_wdata", wd_s, 32'h1122_3344);

    run_access("sb", 1'b1, 3'b000, 32'h0000_4001, 32'h0000_00AB, 32'h0, 0, 0, 1'b0,
               stalls, reqs, bubbles, be_s, wd_s, ad_s);
    chk("sb_be", 32'(be_s), 32'h0000_0002);
    chk("sb_wdata", wd_s, 32'hABAB_ABAB);

    single("sbu_illegal", 2'b00, 1'b1, 3'b100, 32'h0000_5000, 32'h0, req_s, stall_s);
    chk("sbu_req", 32'(req_s), 32'h0);
    chk("sbu_flag", 32'(misaligned_out), 32'h1);

    single("w011_illegal", 2'b01, 1'b0, 3'b011, 32'h0000_6000, 32'h0, req_s, stall_s);
    chk("w011_req", 32'(req_s), 32'h0);
    chk("w011_flag", 32'(misaligned_out), 32'h1);

    // reset while waiting for read data; a late rvalid must be dropped
    @(posedge clk); #2;
    set_op(1'b1, 1'b1, 5'd4, 2'b01, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h0);
    dmem.gnt = 1'b1;
    @(posedge clk); #2;
    bus_idle();
    reset = 1'b0;
    bubble();
    @(negedge clk);
    chk("rst_mid_valid", 32'(valid_out), 32'h0);
    chk("rst_mid_req", 32'(dmem.req), 32'h0);
    @(posedge clk); #2;
    reset = 1'b1;
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'h5555_AAAA;
    @(negedge clk);
    chk("late_rvalid_stall", 32'(stall_out), 32'h0);
    @(posedge clk); #2;
    bus_idle();
    @(negedge clk);
    chk("late_rvalid_valid", 32'(valid_out), 32'h0);
    chk("late_rvalid_wb", wb_data_out, 32'h0);
    $display("txn reset_in_wait valid=%0d wb=%h", valid_out, wb_data_out);

    // FSM must be back in IDLE: a fresh load completes normally
    run_access("lw_after_reset", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'hA5A5_0F0F, 0, 1, 1'b0,
               stalls, reqs, bubbles, be_s, wd_s, ad_s);
    chk("post_rst_wb", wb_data_out, 32'hA5A5_0F0F);
    chk("post_rst_stalls", 32'(stalls), 32'd1);

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
